// File: rtl/afbc_block_encoder.sv
// rtl/afbc_block_encoder.sv - AFBC-style block encoder: solid-block detection, header plus raw payload beats
//
// Accepts one block of NPIX pixels, inspects it for a single repeated colour and
// emits a header beat followed, for non-solid blocks, by the raw block split into
// BEATS = NPIX*PIX_W/OUT_W payload beats.
//
// Build option: define AFBC_SOLID_DETECT_EN to enable solid-block detection.
// Without it every block is emitted raw.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   blk_valid/blk_ready   input block handshake, blk_pixels pixel i at [i*PIX_W +: PIX_W]
//   cmp_valid/cmp_ready   output beat handshake, cmp_data beat, cmp_last end of block
//   perf_blocks_in        blocks accepted (wraps)
//   perf_beats_out        beats handed downstream (wraps)
//   perf_solid_blocks     blocks emitted as solid (wraps)

module afbc_block_encoder #(
    parameter int PIX_W = 32,
    parameter int NPIX  = 16,
    parameter int OUT_W = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  blk_valid,
    input  logic [NPIX*PIX_W-1:0] blk_pixels,
    output logic                  blk_ready,
    output logic                  cmp_valid,
    output logic [OUT_W-1:0]      cmp_data,
    output logic                  cmp_last,
    input  logic                  cmp_ready,
    output logic [31:0]           perf_blocks_in,
    output logic [31:0]           perf_beats_out,
    output logic [31:0]           perf_solid_blocks
);

    localparam int BLK_W = NPIX * PIX_W;
    localparam int BEATS = BLK_W / OUT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BEATS - 1);
    localparam logic [7:0]       BEATS_FIELD = 8'(BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ANALYZE = 2'd1,
        HDR     = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [BLK_W-1:0] buffer;
    logic             solid;
    logic             solid_calc;
    logic [IDX_W-1:0] beat_idx;
    logic [OUT_W-1:0] header;
    logic             accept;
    logic             beat_hs;

    assign accept  = blk_valid && blk_ready;
    assign beat_hs = cmp_valid && cmp_ready;

`ifdef AFBC_SOLID_DETECT_EN
    // Solid means every pixel matches pixel 0 of the buffered block.
    always_comb begin
        solid_calc = 1'b1;
        for (int i = 1; i < NPIX; i++) begin
            if (buffer[i*PIX_W +: PIX_W] != buffer[PIX_W-1:0]) begin
                solid_calc = 1'b0;
            end
        end
    end
`else
    assign solid_calc = 1'b0;
`endif

    // Header: mode in [1:0], solid colour above it, payload beat count above that.
    always_comb begin
        header                    = '0;
        header[1:0]               = solid ? 2'b01 : 2'b00;
        header[PIX_W+1:2]         = solid ? buffer[PIX_W-1:0] : '0;
        header[PIX_W+9:PIX_W+2]   = solid ? 8'd0 : BEATS_FIELD;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (blk_valid) state_next = ANALYZE;
            ANALYZE: state_next = HDR;
            HDR:     if (cmp_ready) state_next = solid ? IDLE : PAYLOAD;
            PAYLOAD: if (cmp_ready && (beat_idx == LAST_IDX)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on state and registered data, so they stay stable
    // while downstream stalls.
    always_comb begin
        blk_ready = 1'b0;
        cmp_valid = 1'b0;
        cmp_last  = 1'b0;
        cmp_data  = '0;
        case (state)
            IDLE: blk_ready = 1'b1;
            HDR: begin
                cmp_valid = 1'b1;
                cmp_last  = solid;
                cmp_data  = header;
            end
            PAYLOAD: begin
                cmp_valid = 1'b1;
                cmp_last  = (beat_idx == LAST_IDX);
                cmp_data  = buffer[beat_idx*OUT_W +: OUT_W];
            end
            default: ;
        endcase
    end

    // Block buffer, solid flag, payload index and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer            <= '0;
            solid             <= 1'b0;
            beat_idx          <= '0;
            perf_blocks_in    <= '0;
            perf_beats_out    <= '0;
            perf_solid_blocks <= '0;
        end else begin
            if (accept) begin
                buffer         <= blk_pixels;
                perf_blocks_in <= perf_blocks_in + 32'd1;
            end
            if (state == ANALYZE) begin
                solid <= solid_calc;
            end
            if (state == HDR) begin
                beat_idx <= '0;
            end else if ((state == PAYLOAD) && cmp_ready) begin
                beat_idx <= beat_idx + 1'b1;
            end
            if (beat_hs) begin
                perf_beats_out <= perf_beats_out + 32'd1;
            end
            if (beat_hs && (state == HDR) && solid) begin
                perf_solid_blocks <= perf_solid_blocks + 32'd1;
            end
        end
    end

endmodule

// File: doc/afbc_block_encoder.md
AFBC_BLOCK_ENCODER -- requirements
Module: afbc_block_encoder

Interface
REQ-001 SHALL have parameter PIX_W, default 32, bits per pixel.
REQ-002 SHALL have parameter NPIX, default 16, pixels per input block.
REQ-003 SHALL have parameter OUT_W, default 128, output beat width; NPIX*PIX_W SHALL be an integer multiple of OUT_W, with BEATS = NPIX*PIX_W/OUT_W.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port blk_valid  input  1  input block valid.
REQ-007 SHALL have port blk_pixels  input  NPIX*PIX_W  block pixels; pixel i at bits [i*PIX_W +: PIX_W].
REQ-008 SHALL have port blk_ready  output  1  block accepted when blk_valid && blk_ready.
REQ-009 SHALL have port cmp_valid  output  1  output beat valid.
REQ-010 SHALL have port cmp_data  output  OUT_W  output beat.
REQ-011 SHALL have port cmp_last  output  1  final beat of the current block.
REQ-012 SHALL have port cmp_ready  input  1  downstream accepts beat when cmp_valid && cmp_ready.
REQ-013 SHALL have ports perf_blocks_in, perf_beats_out, perf_solid_blocks  output  32 each  statistics counters.

Function
REQ-014 SHALL implement FSM IDLE -> ANALYZE -> HDR -> (PAYLOAD | IDLE); blk_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance SHALL register blk_pixels into an internal buffer, increment perf_blocks_in, and go to ANALYZE.
REQ-016 ANALYZE SHALL last exactly one cycle; SHALL set solid=1 iff every pixel equals pixel 0; SHALL then go to HDR.
REQ-017 In HDR, cmp_valid=1 and cmp_data = header: bits[1:0] mode (2'b01 solid, 2'b00 raw), bits[PIX_W+1:2] pixel 0 if solid else zero, bits[9+PIX_W:2+PIX_W] = number of payload beats (0 or BEATS), remaining bits zero.
REQ-018 First header beat SHALL present cmp_valid in the second cycle after the acceptance cycle.
REQ-019 Solid block: header cmp_last=1; on handshake SHALL increment perf_solid_blocks and return to IDLE.
REQ-020 Raw block: header cmp_last=0; on handshake SHALL go to PAYLOAD, beat index k=0.
REQ-021 PAYLOAD beat k SHALL carry buffer bits [k*OUT_W +: OUT_W]; cmp_last=1 only for k=BEATS-1; after final handshake SHALL return to IDLE.
REQ-022 While cmp_valid=1 and cmp_ready=0, cmp_data, cmp_last and state SHALL hold unchanged; cmp_valid SHALL not drop without a handshake.
REQ-023 perf_beats_out SHALL increment by 1 per output handshake; all counters SHALL wrap modulo 2^32.
REQ-024 Back-to-back: next block SHALL be accepted the cycle after the last beat handshake (IDLE), no earlier.
REQ-025 cmp_valid SHALL be 0 in IDLE and ANALYZE; cmp_last SHALL be 0 whenever cmp_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cmp_valid=0, cmp_last=0, cmp_data=0, all perf counters=0, blk_ready=1 after reset release.
REQ-027 Reset mid-block SHALL discard the partial block; no further beats of it SHALL be emitted.

Configuration
REQ-028 With macro AFBC_SOLID_DETECT_EN defined, solid detection SHALL operate per REQ-016..019.
REQ-029 Without AFBC_SOLID_DETECT_EN, solid SHALL be forced 0: every block emits raw header plus BEATS payload beats, and perf_solid_blocks SHALL stay 0.

Verification
REQ-030 Defaults, all 16 pixels = 0xDEADBEEF, cmp_ready=1 -> one beat, data[1:0]=01, data[33:2]=0xDEADBEEF, cmp_last=1, perf_solid_blocks=1.
REQ-031 Defaults, pixel i = i -> header mode 00 with payload count 4, then 4 beats equal to blk_pixels slices 0..3, cmp_last only on 4th, perf_beats_out=5.
REQ-032 Raw block with cmp_ready toggling 1,0,0,1 each cycle -> beats stable while stalled, no beat lost or duplicated, order preserved.
REQ-033 rst_n asserted during PAYLOAD beat 2 -> cmp_valid=0 immediately, counters 0, next block starts with fresh header.
REQ-034 Build without AFBC_SOLID_DETECT_EN, solid block input -> raw header plus 4 payload beats, perf_solid_blocks=0.
REQ-035 Preload perf_blocks_in near 0xFFFFFFFF via 2^32-1 blocks (or force) then one block -> counter wraps to 0.
